// File: rtl/seg_cmd_decoder.sv
// SPI command decoder driving a multiplexed, PWM-dimmed 7-segment display.
// Optional blink support is compiled in with the SEG_BLINK_EN macro.
module seg_cmd_decoder #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cs_n,
  input  logic                  i_rx_valid,
  input  logic [7:0]            i_rx_data,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_load,
  output logic [7:0]            o_seg,
  output logic [NUM_DIGITS-1:0] o_digit_en,
  output logic                  o_err
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [4:0] ND5 = 5'(NUM_DIGITS);

  typedef enum logic {
    S_IDLE,
    S_ARG
  } state_t;

  typedef enum logic [1:0] {
    OP_RAW,
    OP_HEX,
    OP_BRT,
    OP_BLK
  } op_t;

  state_t          r_state;
  op_t             r_op;
  logic [3:0]      r_dn;
  logic            r_bad;
  logic [7:0]      r_dig [NUM_DIGITS];
  logic [3:0]      r_brt;
  logic            r_err;
  logic [7:0]      r_tx_data;
  logic            r_tx_load;
  logic [CW-1:0]   r_scan;
  logic [IW-1:0]   r_idx;
  logic [7:0]      r_seg;
  logic [NUM_DIGITS-1:0] r_en;

  logic       w_is_raw;
  logic       w_is_hex;
  logic       w_is_brt;
  logic       w_is_clr;
  logic       w_is_sts;
  logic       w_dn_ok;
  logic [3:0] w_hi4;
  logic       w_on;
  logic       w_wrap;
  logic       w_blank;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'h3F;
      4'h1:    hex7 = 7'h06;
      4'h2:    hex7 = 7'h5B;
      4'h3:    hex7 = 7'h4F;
      4'h4:    hex7 = 7'h66;
      4'h5:    hex7 = 7'h6D;
      4'h6:    hex7 = 7'h7D;
      4'h7:    hex7 = 7'h07;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h6F;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h7C;
      4'hC:    hex7 = 7'h39;
      4'hD:    hex7 = 7'h5E;
      4'hE:    hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign w_is_raw = (i_rx_data[7:4] == 4'h1);
  assign w_is_hex = (i_rx_data[7:4] == 4'h2);
  assign w_is_brt = (i_rx_data == 8'h30);
  assign w_is_clr = (i_rx_data == 8'h40);
  assign w_is_sts = (i_rx_data == 8'h50);
  assign w_dn_ok  = ({1'b0, i_rx_data[3:0]} < ND5);

  assign w_hi4  = r_scan[CW-1 -: 4];
  assign w_on   = (w_hi4 <= r_brt);
  assign w_wrap = (r_scan == CW'(SCAN_DIV - 1));

`ifdef SEG_BLINK_EN
  logic                  w_is_blk;
  logic [NUM_DIGITS-1:0] r_blink;
  logic [7:0]            r_bcnt;

  assign w_is_blk = (i_rx_data == 8'h60);
  assign w_blank  = r_bcnt[7] & r_blink[r_idx];
`else
  assign w_blank = 1'b0;
`endif

  // Command FSM: opcode byte latches op and digit, argument byte commits
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_op      <= OP_RAW;
      r_dn      <= '0;
      r_bad     <= 1'b0;
      r_brt     <= 4'hF;
      r_err     <= 1'b0;
      r_tx_data <= 8'h00;
      r_tx_load <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) r_dig[i] <= 8'h00;
`ifdef SEG_BLINK_EN
      r_blink   <= '0;
`endif
    end else begin
      r_tx_load <= 1'b0;
      if (i_cs_n) begin
        r_state <= S_IDLE;
      end else if (i_rx_valid) begin
        unique case (r_state)
          S_IDLE: begin
            unique case (1'b1)
              w_is_raw, w_is_hex: begin
                r_op    <= w_is_raw ? OP_RAW : OP_HEX;
                r_dn    <= i_rx_data[3:0];
                r_bad   <= !w_dn_ok;
                r_state <= S_ARG;
                if (!w_dn_ok) r_err <= 1'b1;
              end
              w_is_brt: begin
                r_op    <= OP_BRT;
                r_bad   <= 1'b0;
                r_state <= S_ARG;
              end
`ifdef SEG_BLINK_EN
              w_is_blk: begin
                r_op    <= OP_BLK;
                r_bad   <= 1'b0;
                r_state <= S_ARG;
              end
`endif
              w_is_clr: begin
                for (int i = 0; i < NUM_DIGITS; i++) r_dig[i] <= 8'h00;
`ifdef SEG_BLINK_EN
                r_blink <= '0;
`endif
              end
              w_is_sts: begin
                r_tx_data <= {r_err, 3'b000, r_brt};
                r_tx_load <= 1'b1;
                r_err     <= 1'b0;
              end
              default: r_err <= 1'b1;
            endcase
          end
          S_ARG: begin
            r_state <= S_IDLE;
            if (!r_bad) begin
              unique case (r_op)
                OP_RAW: r_dig[r_dn[IW-1:0]] <= i_rx_data;
                OP_HEX: r_dig[r_dn[IW-1:0]] <=
                          {i_rx_data[7], hex7(i_rx_data[3:0])};
                OP_BRT: r_brt <= i_rx_data[3:0];
`ifdef SEG_BLINK_EN
                OP_BLK: r_blink <= i_rx_data[NUM_DIGITS-1:0];
`else
                OP_BLK: r_state <= S_IDLE;
`endif
              endcase
            end
          end
        endcase
      end
    end
  end

  // Scan slot counter and registered display drive
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_scan <= '0;
      r_idx  <= '0;
      r_seg  <= 8'h00;
      r_en   <= '0;
`ifdef SEG_BLINK_EN
      r_bcnt <= 8'h00;
`endif
    end else begin
      r_scan <= w_wrap ? '0 : r_scan + CW'(1);
      if (w_wrap) begin
        r_idx <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + IW'(1);
`ifdef SEG_BLINK_EN
        r_bcnt <= r_bcnt + 8'd1;
`endif
      end
      if (w_on && !w_blank) begin
        r_en  <= NUM_DIGITS'(1) << r_idx;
        r_seg <= r_dig[r_idx];
      end else begin
        r_en  <= '0;
        r_seg <= 8'h00;
      end
    end
  end

  assign o_tx_data  = r_tx_data;
  assign o_tx_load  = r_tx_load;
  assign o_seg      = r_seg;
  assign o_digit_en = r_en;
  assign o_err      = r_err;

endmodule

// File: tb/tb_seg_cmd_decoder.sv
// Directed bench for seg_cmd_decoder: per-cycle display check plus
// a status-byte scoreboard.
module tb_seg_cmd_decoder;

  logic       clk;
  logic       rst_n;
  logic       cs_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic       tx_load;
  logic [7:0] seg;
  logic [3:0] digit_en;
  logic       err;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] txq[$];
  logic [7:0] mdig [4];
  logic [3:0] mbr;
  logic [3:0] mcnt;
  logic [1:0] midx;
  logic [7:0] mbc;
  logic [3:0] mmask;

  seg_cmd_decoder #(
    .NUM_DIGITS(4),
    .SCAN_DIV  (16)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_cs_n    (cs_n),
    .i_rx_valid(rx_valid),
    .i_rx_data (rx_data),
    .o_tx_data (tx_data),
    .o_tx_load (tx_load),
    .o_seg     (seg),
    .o_digit_en(digit_en),
    .o_err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: expected display comes from the state before the edge
  task automatic tick();
    logic       on;
    logic [3:0] en_e;
    logic [7:0] seg_e;
    on = (mcnt <= mbr);
    if (mbc[7] && mmask[midx]) on = 1'b0;
    en_e  = on ? (4'b0001 << midx) : 4'b0000;
    seg_e = on ? mdig[midx] : 8'h00;
    @(posedge clk);
    #1;
    chk("digit_en", digit_en, en_e);
    chk("seg", seg, seg_e);
    if (tx_load) begin
      if (txq.size() == 0) chk("tx_spurious", tx_load, 0);
      else chk("tx_data", tx_data, txq.pop_front());
    end
    if (mcnt == 4'hF) begin
      midx = midx + 2'd1;
`ifdef SEG_BLINK_EN
      mbc = mbc + 8'd1;
`endif
    end
    mcnt = mcnt + 4'd1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  initial begin
    rst_n    = 1'b0;
    cs_n     = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    for (int i = 0; i < 4; i++) mdig[i] = 8'h00;
    mbr   = 4'hF;
    mcnt  = 4'h0;
    midx  = 2'd0;
    mbc   = 8'h00;
    mmask = 4'h0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", seg, 8'h00);
    chk("rst_en", digit_en, 4'h0);
    chk("rst_err", err, 0);
    chk("rst_txload", tx_load, 0);
    chk("rst_txdata", tx_data, 8'h00);
    rst_n = 1'b1;

    // idle scan, full brightness, blank digits
    run(64);
    chk("idle_err", err, 0);

    cs_n = 1'b0;
    send(8'h21);
    send(8'h85);
    mdig[1] = 8'hED;
    run(64);
    send(8'h20);
    send(8'h0A);
    mdig[0] = 8'h77;
    send(8'h13);
    send(8'h5A);
    mdig[3] = 8'h5A;
    run(64);
    chk("write_err", err, 0);

    send(8'h30);
    send(8'h03);
    mbr = 4'h3;
    run(64);

    // out-of-range digit: argument swallowed, err raised
    send(8'h17);
    send(8'hAA);
    chk("badidx_err", err, 1);
    run(16);
    txq.push_back(8'h83);
    send(8'h50);
    chk("sts1_pending", txq.size(), 0);
    chk("sts1_errclr", err, 0);
    run(4);

    // abort mid-command; next byte is a fresh opcode
    send(8'h12);
    cs_n = 1'b1;
    tick();
    cs_n = 1'b0;
    tick();
    send(8'h55);
    chk("abort_err", err, 1);
    run(64);
    txq.push_back(8'h83);
    send(8'h50);
    chk("sts2_pending", txq.size(), 0);
    chk("sts2_errclr", err, 0);

    // strobe while deselected is ignored
    cs_n = 1'b1;
    send(8'h40);
    run(32);
    cs_n = 1'b0;

    // strobe coinciding with cs_n rising is ignored
    send(8'h12);
    cs_n     = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h99;
    tick();
    rx_valid = 1'b0;
    cs_n     = 1'b0;
    tick();
    run(64);
    chk("edge_err", err, 0);

    send(8'h30);
    send(8'h00);
    mbr = 4'h0;
    run(64);
    send(8'h30);
    send(8'h0F);
    mbr = 4'hF;
    run(32);

`ifdef SEG_BLINK_EN
    send(8'h60);
    send(8'h01);
    mmask = 4'h1;
    run(4200);
    chk("blink_err", err, 0);
`else
    send(8'h60);
    chk("op60_err", err, 1);
    txq.push_back(8'h8F);
    send(8'h50);
    chk("sts3_pending", txq.size(), 0);
    chk("sts3_errclr", err, 0);
`endif

    send(8'h40);
    for (int i = 0; i < 4; i++) mdig[i] = 8'h00;
    mmask = 4'h0;
    run(64);
    chk("final_err", err, 0);
    chk("txq_empty", txq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/seg_cmd_decoder.md
Name: seg_cmd_decoder

Overview:
- Consumes bytes delivered by the SPI receiver stage (one-cycle rx_valid strobe plus rx_data) and decodes a small command set.
- Maintains the per-digit segment registers and the brightness setting.
- Drives a time-multiplexed, PWM-dimmed 7-segment display.
- Can load a status byte back to the SPI transmit path.

Parameters:
- NUM_DIGITS, 4: digits driven; 1..8.
- SCAN_DIV, 1024: clocks per digit scan slot; power of two, >=16.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cs_n  in  1  SPI chip select, active-low, already synchronised to clk; marks the frame.
- rx_valid  in  1  one-cycle strobe: rx_data holds a complete received byte.
- rx_data  in  8  received byte, MSB first as assembled upstream.
- tx_data  out  8  status byte for the SPI transmitter.
- tx_load  out  1  one-cycle strobe: tx_data valid.
- seg  out  8  {dp,g,f,e,d,c,b,a}, active-high, registered.
- digit_en  out  NUM_DIGITS  one-hot digit enable, active-high, registered.
- err  out  1  sticky command error flag.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Digit registers 0, brightness 4'hF, err 0, tx_data 8'h00, tx_load 0.
  - FSM IDLE, scan counter 0, digit index 0, seg 0, digit_en 0.
- FSM states: IDLE and GET_ARG (latched opcode and digit index). A byte is accepted only when rx_valid=1 and cs_n=0.
- IDLE, accepted byte, by opcode:
  - 0x1n (raw write to digit n) or 0x2n (hex write to digit n): go to GET_ARG.
  - 0x30 (brightness): go to GET_ARG.
  - 0x40 (clear): all digit registers to 0 on the next cycle; stay in IDLE.
  - 0x50 (status read): next cycle tx_data={err,3'b000,brightness} and tx_load=1 for exactly one cycle; err clears on the same edge. Stay in IDLE.
  - Any other value: err<=1; stay in IDLE.
- GET_ARG, accepted byte, written on the next edge, then back to IDLE:
  - 0x1n: digit[n]<=rx_data.
  - 0x2n: digit[n]<={rx_data[7], hex7(rx_data[3:0])}. hex7 uses standard 0-F glyphs (0=7'h3F, 1=7'h06, ..., F=7'h71 in g..a order).
  - 0x30: brightness<=rx_data[3:0].
- Digit index n >= NUM_DIGITS:
  - err<=1.
  - The FSM still enters GET_ARG, and the argument byte is consumed and discarded, so framing is preserved.
- Frame abort: cs_n=1 forces the FSM to IDLE on the next edge and discards a partial command.
  - rx_valid with cs_n=1 is ignored.
  - rx_valid and cs_n rising in the same cycle: the byte is ignored.
- Scan counter:
  - 0..SCAN_DIV-1, free-running.
  - On wrap, the digit index advances modulo NUM_DIGITS.
  - hi4 = top 4 bits of the counter.
- Slot on: slot_on = (hi4 <= brightness). Brightness 15 is 100% on; 0 is 1/16 duty.
- Registered outputs, one cycle after the counter value:
  - Slot on: digit_en=onehot(index), seg=digit[index].
  - Slot off: digit_en=0, seg=0.
- A register write becomes visible the next time its digit is scanned. No glitch within a slot beyond the one-cycle output register.
- No other outputs change during a command except as listed.

Optional Feature:
- Macro SEG_BLINK_EN.
- Defined:
  - Opcode 0x60 takes one argument byte; blink_mask<=arg[NUM_DIGITS-1:0]. Reset value 0.
  - An 8-bit counter increments on each scan-slot wrap; phase = its MSB.
  - While phase=1, digits whose blink_mask bit is set are blanked (digit_en=0, seg=0).
  - 0x40 also clears blink_mask.
- Undefined:
  - 0x60 is an unknown opcode and sets err.
  - No blink logic or counter is instantiated.

Test Plan:
- Reset, then idle with NUM_DIGITS=4, SCAN_DIV=16 -> digit_en cycles 0001,0010,0100,1000 every 16 clocks; seg=8'h00; err=0.
- cs_n=0; bytes 0x21, 0x85 -> digit[1]=8'hED (dp + glyph 5); seg=8'hED while digit_en=0010.
- Bytes 0x30, 0x03 -> in each 16-clock slot digit_en is high for 4 clocks (hi4 0..3), low for 12.
- Bytes 0x17, 0xAA -> err=1, argument consumed, no digit changes; then 0x50 -> tx_load pulse, tx_data=8'h83 (brightness 3 retained from the previous case), err=0 next cycle.
- Byte 0x12, then cs_n=1 before the argument; new frame with byte 0x55 -> 0x55 is treated as an opcode (unknown, err=1); digit[2] unchanged.
- With SEG_BLINK_EN defined: bytes 0x60, 0x01 -> digit 0 blanked for 128 slot-wraps, shown for 128; other digits unaffected. Without the macro: 0x60 sets err.
